// File: rtl/pe_out_collector.sv
// Output drain for a PE column: keeps stride-grid window positions, rounds/saturates them,
// tags them with output row/col and queues them behind a valid/ready FIFO. Optional macro: COLLECTOR_RELU_EN.
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef FM_SIZE
`define FM_SIZE 4
`endif
`ifndef PADDING
`define PADDING 0
`endif
`ifndef STRIDE
`define STRIDE 1
`endif
`ifndef OUTPUT_DSP_WIDTH
`define OUTPUT_DSP_WIDTH 48
`endif

module pe_out_collector #(
    parameter int KERNEL_SIZE = `KERNEL_SIZE,
    parameter int FM_SIZE     = `FM_SIZE,
    parameter int PADDING     = `PADDING,
    parameter int STRIDE      = `STRIDE,
    parameter int OUT_WIDTH   = 16,
    parameter int FRAC_SHIFT  = 0,
    parameter int FIFO_DEPTH  = 8,
    localparam int W        = FM_SIZE + 2*PADDING - KERNEL_SIZE + 1,
    localparam int OUT_SIZE = ((FM_SIZE - KERNEL_SIZE + 2*PADDING)/STRIDE) + 1,
    localparam int TW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic signed [`OUTPUT_DSP_WIDTH-1:0] i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic signed [OUT_WIDTH-1:0]   o_data,
    output logic [TW-1:0]                 o_row,
    output logic [TW-1:0]                 o_col,
    output logic                          o_last,
    output logic                          o_frame_done,
    output logic                          o_overflow
);
    localparam int DW = `OUTPUT_DSP_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] POS_MAX = CW'(W - 1);
    localparam logic [PW-1:0] PH_MAX  = PW'(STRIDE - 1);
    localparam logic [TW-1:0] TAG_MAX = TW'(OUT_SIZE - 1);

    localparam logic signed [DW:0] RND =
        (FRAC_SHIFT > 0) ? ((DW+1)'(1) << ((FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0)) : '0;
    localparam logic signed [DW:0] SAT_MAX = {{(DW+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DW:0] SAT_MIN = {{(DW+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [CW-1:0] pos_r, pos_c;
    logic [PW-1:0] ph_r, ph_c;
    logic [TW-1:0] out_r, out_c;

    // Raster counters; phase/output counters track pos mod STRIDE and pos/STRIDE without dividers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos_r <= '0; pos_c <= '0;
            ph_r  <= '0; ph_c  <= '0;
            out_r <= '0; out_c <= '0;
        end else if (i_en) begin
            if (pos_c == POS_MAX) begin
                pos_c <= '0; ph_c <= '0; out_c <= '0;
                if (pos_r == POS_MAX) begin
                    pos_r <= '0; ph_r <= '0; out_r <= '0;
                end else begin
                    pos_r <= pos_r + 1'b1;
                    if (ph_r == PH_MAX) begin
                        ph_r  <= '0;
                        out_r <= out_r + 1'b1;
                    end else begin
                        ph_r <= ph_r + 1'b1;
                    end
                end
            end else begin
                pos_c <= pos_c + 1'b1;
                if (ph_c == PH_MAX) begin
                    ph_c  <= '0;
                    out_c <= out_c + 1'b1;
                end else begin
                    ph_c <= ph_c + 1'b1;
                end
            end
        end
    end

    logic accept;
    logic signed [DW:0] ext, rounded, shifted;
    logic [OUT_WIDTH-1:0] sat_val;

    // One extra bit of headroom so the rounding add cannot wrap.
    always_comb begin
        accept  = i_en && (ph_r == '0) && (ph_c == '0);
        ext     = {i_data[DW-1], i_data};
        rounded = ext + RND;
        shifted = rounded >>> FRAC_SHIFT;
        if (shifted > SAT_MAX)
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
        else
            sat_val = shifted[OUT_WIDTH-1:0];
`ifdef COLLECTOR_RELU_EN
        if (sat_val[OUT_WIDTH-1])
            sat_val = '0;
`endif
    end

    logic                 s1_valid, s1_last;
    logic [OUT_WIDTH-1:0] s1_data;
    logic [TW-1:0]        s1_row, s1_col;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= sat_val;
                s1_row  <= out_r;
                s1_col  <= out_c;
                s1_last <= (out_r == TAG_MAX) && (out_c == TAG_MAX);
            end
        end
    end

    logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [TW-1:0]        mem_row  [FIFO_DEPTH];
    logic [TW-1:0]        mem_col  [FIFO_DEPTH];
    logic                 mem_last [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 empty, full, push, pop;

    // Upstream cannot stall, so a full FIFO without a pop this cycle loses the sample.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = !empty && i_ready;
        push  = s1_valid && (!full || pop);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= s1_data;
            mem_row[wr_ptr[AW-1:0]]  <= s1_row;
            mem_col[wr_ptr[AW-1:0]]  <= s1_col;
            mem_last[wr_ptr[AW-1:0]] <= s1_last;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_overflow   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (s1_valid && !push)
                o_overflow <= 1'b1;
            o_frame_done <= pop && mem_last[rd_ptr[AW-1:0]];
        end
    end

    // Head fields are forced to zero when empty so reset and idle present a clean bus.
    always_comb begin
        o_valid = !empty;
        o_data  = o_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
        o_row   = o_valid ? mem_row[rd_ptr[AW-1:0]]  : '0;
        o_col   = o_valid ? mem_col[rd_ptr[AW-1:0]]  : '0;
        o_last  = o_valid ? mem_last[rd_ptr[AW-1:0]] : 1'b0;
    end

endmodule

// File: tb/tb_pe_out_collector.sv
// Self-checking bench for pe_out_collector: directed tables on two configurations
// (W=2/S=1/depth 4 and W=5/S=2/FRAC_SHIFT=4) plus a randomized run against a queue model.
module tb_pe_out_collector;

    logic clk = 1'b0;
    logic rst, en, ready;
    logic signed [47:0] din;

    logic              a_valid, a_last, a_fd, a_ovf;
    logic signed [15:0] a_data;
    logic [0:0]        a_row, a_col;
    logic              b_valid, b_last, b_fd, b_ovf;
    logic signed [15:0] b_data;
    logic [1:0]        b_row, b_col;

    always #5 clk = ~clk;

    pe_out_collector #(
        .KERNEL_SIZE(3), .FM_SIZE(4), .PADDING(0), .STRIDE(1),
        .OUT_WIDTH(16), .FRAC_SHIFT(0), .FIFO_DEPTH(4)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(din),
        .o_valid(a_valid), .i_ready(ready), .o_data(a_data),
        .o_row(a_row), .o_col(a_col), .o_last(a_last),
        .o_frame_done(a_fd), .o_overflow(a_ovf)
    );

    pe_out_collector #(
        .KERNEL_SIZE(1), .FM_SIZE(5), .PADDING(0), .STRIDE(2),
        .OUT_WIDTH(16), .FRAC_SHIFT(4), .FIFO_DEPTH(8)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(din),
        .o_valid(b_valid), .i_ready(ready), .o_data(b_data),
        .o_row(b_row), .o_col(b_col), .o_last(b_last),
        .o_frame_done(b_fd), .o_overflow(b_ovf)
    );

    typedef struct {
        int data;
        int row;
        int col;
        bit last;
    } rec_t;

    typedef struct {
        longint din;
        int     exp_data;
        int     exp_row;
        int     exp_col;
        bit     exp_last;
    } vec_t;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;

    rec_t   cap_a[$];
    rec_t   cap_b[$];
    longint last_pop_cyc_a = -1;
    longint fd_cyc_a = -1;
    int     fd_cnt_a = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every handshake-completed element seen on each output port.
    always @(negedge clk) begin
        if (a_valid && ready) begin
            cap_a.push_back(rec_t'{int'(a_data), int'(a_row), int'(a_col), a_last});
            if (a_last)
                last_pop_cyc_a = cyc;
        end
        if (a_fd) begin
            fd_cnt_a++;
            fd_cyc_a = cyc;
        end
        if (b_valid && ready)
            cap_b.push_back(rec_t'{int'(b_data), int'(b_row), int'(b_col), b_last});
    end

    // Behavioural model state for the randomized run, index 0 = dut_a, 1 = dut_b.
    int   cfg_w[2]  = '{2, 5};
    int   cfg_s[2]  = '{1, 2};
    int   cfg_os[2] = '{2, 3};
    int   cfg_d[2]  = '{4, 8};
    int   cfg_fs[2] = '{0, 4};
    int   m_k[2];
    bit   m_s1v[2];
    rec_t m_s1[2];
    rec_t mq[2][16];
    int   mh[2];
    int   mc[2];
    bit   m_ovf[2];
    bit   m_fd[2];

    function automatic int expectValue(input longint d, input int fs);
        longint v;
        v = d;
        if (fs > 0)
            v = v + (64'sd1 <<< (fs - 1));
        v = v >>> fs;
        if (v > 32767)
            v = 32767;
        if (v < -32768)
            v = -32768;
`ifdef COLLECTOR_RELU_EN
        if (v < 0)
            v = 0;
`endif
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRec(input string name, input rec_t got, input vec_t exp);
        checkOutput({name, "_data"}, got.data, exp.exp_data);
        checkOutput({name, "_row"},  got.row,  exp.exp_row);
        checkOutput({name, "_col"},  got.col,  exp.exp_col);
        checkOutput({name, "_last"}, got.last, exp.exp_last);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_a_valid", a_valid, 0);
        checkOutput("rst_a_data",  a_data,  0);
        checkOutput("rst_a_row",   a_row,   0);
        checkOutput("rst_a_col",   a_col,   0);
        checkOutput("rst_a_last",  a_last,  0);
        checkOutput("rst_a_fd",    a_fd,    0);
        checkOutput("rst_a_ovf",   a_ovf,   0);
        checkOutput("rst_b_valid", b_valid, 0);
        checkOutput("rst_b_ovf",   b_ovf,   0);
    endtask

    task automatic doReset();
        en = 1'b0;
        din = '0;
        ready = 1'b1;
        rst = 1'b1;
        #1;
        checkResetOutputs();
        tick();
        tick();
        rst = 1'b0;
        cap_a.delete();
        cap_b.delete();
        fd_cnt_a = 0;
        fd_cyc_a = -1;
        last_pop_cyc_a = -1;
        for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_s1v[i] = 0; mh[i] = 0; mc[i] = 0; m_ovf[i] = 0; m_fd[i] = 0;
        end
    endtask

    task automatic applyStimulus(input bit e, input longint d);
        en = e;
        din = d[47:0];
        tick();
    endtask

    // Advance the model of one configuration across the next clock edge.
    task automatic modelStep(input int id, input bit e, input longint d, input bit r);
        bit pop, push;
        int rr, cc;
        pop = (mc[id] > 0) && r;
        m_fd[id] = pop && mq[id][mh[id]].last;
        push = m_s1v[id] && ((mc[id] < cfg_d[id]) || pop);
        if (m_s1v[id] && !push)
            m_ovf[id] = 1'b1;
        if (pop) begin
            mh[id] = (mh[id] + 1) % 16;
            mc[id]--;
        end
        if (push) begin
            mq[id][(mh[id] + mc[id]) % 16] = m_s1[id];
            mc[id]++;
        end
        if (e) begin
            rr = m_k[id] / cfg_w[id];
            cc = m_k[id] % cfg_w[id];
            m_s1v[id] = (rr % cfg_s[id] == 0) && (cc % cfg_s[id] == 0);
            m_s1[id] = '{expectValue(d, cfg_fs[id]), rr / cfg_s[id], cc / cfg_s[id],
                         (rr / cfg_s[id] == cfg_os[id] - 1) && (cc / cfg_s[id] == cfg_os[id] - 1)};
            m_k[id] = (m_k[id] + 1) % (cfg_w[id] * cfg_w[id]);
        end else begin
            m_s1v[id] = 1'b0;
        end
    endtask

    task automatic compareModel(input int id);
        bit av, al, afd, aov;
        int ad, ar, ac;
        string tag;
        tag = (id == 0) ? "rnd_a" : "rnd_b";
        if (id == 0) begin
            av = a_valid; ad = int'(a_data); ar = int'(a_row); ac = int'(a_col);
            al = a_last; afd = a_fd; aov = a_ovf;
        end else begin
            av = b_valid; ad = int'(b_data); ar = int'(b_row); ac = int'(b_col);
            al = b_last; afd = b_fd; aov = b_ovf;
        end
        checkOutput({tag, "_valid"}, av, (mc[id] > 0) ? 1 : 0);
        if (mc[id] > 0) begin
            checkOutput({tag, "_data"}, ad, mq[id][mh[id]].data);
            checkOutput({tag, "_row"},  ar, mq[id][mh[id]].row);
            checkOutput({tag, "_col"},  ac, mq[id][mh[id]].col);
            checkOutput({tag, "_last"}, al, mq[id][mh[id]].last);
        end
        checkOutput({tag, "_frame_done"}, afd, m_fd[id]);
        checkOutput({tag, "_overflow"},   aov, m_ovf[id]);
    endtask

    vec_t t1[4];
    vec_t t2[9];
    vec_t t3[4];
    vec_t t4[3];
    vec_t t5[4];

    initial begin
        t1[0] = '{5, 5, 0, 0, 1'b0};
        t1[1] = '{-3, -3, 0, 1, 1'b0};
        t1[2] = '{7, 7, 1, 0, 1'b0};
        t1[3] = '{9, 9, 1, 1, 1'b1};
        for (int i = 0; i < 9; i++)
            t2[i] = '{0, (i / 3) * 10 + (i % 3) * 2, i / 3, i % 3, (i == 8)};
        t3[0] = '{70000, 32767, 0, 0, 1'b0};
`ifdef COLLECTOR_RELU_EN
        t3[1] = '{-70000, 0, 0, 1, 1'b0};
        t4[2] = '{-24, 0, 0, 2, 1'b0};
`else
        t3[1] = '{-70000, -32768, 0, 1, 1'b0};
        t4[2] = '{-24, -1, 0, 2, 1'b0};
`endif
        t3[2] = '{0, 0, 1, 0, 1'b0};
        t3[3] = '{0, 0, 1, 1, 1'b1};
        t4[0] = '{24, 2, 0, 0, 1'b0};
        t4[1] = '{23, 1, 0, 1, 1'b0};
        for (int i = 0; i < 4; i++)
            t5[i] = '{11 + i, 11 + i, i / 2, i % 2, (i == 3)};

        rst = 1'b1; en = 1'b0; din = '0; ready = 1'b1;

        // Basic raster, latency and frame_done on the W=2 configuration.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, t1[i].din);
            if (i == 0) checkOutput("latency_early_valid", a_valid, 0);
            if (i == 1) checkOutput("latency_n2_valid", a_valid, 1);
        end
        applyStimulus(1'b0, 0);
        repeat (8) tick();
        checkOutput("basic_count", cap_a.size(), 4);
        for (int i = 0; i < 4 && i < cap_a.size(); i++)
            checkRec($sformatf("basic%0d", i), cap_a[i], t1[i]);
        checkOutput("frame_done_count", fd_cnt_a, 1);
        checkOutput("frame_done_cycle", fd_cyc_a, last_pop_cyc_a + 1);

        // Stride-2 decimation on the W=5 configuration; inputs pre-scaled for FRAC_SHIFT=4.
        doReset();
        for (int v = 0; v < 25; v++)
            applyStimulus(1'b1, 16 * v);
        applyStimulus(1'b0, 0);
        repeat (12) tick();
        checkOutput("stride_count", cap_b.size(), 9);
        for (int i = 0; i < 9 && i < cap_b.size(); i++)
            checkRec($sformatf("stride%0d", i), cap_b[i], t2[i]);

        // Saturation.
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, t3[i].din);
        applyStimulus(1'b0, 0);
        repeat (8) tick();
        checkOutput("sat_count", cap_a.size(), 4);
        for (int i = 0; i < 4 && i < cap_a.size(); i++)
            checkRec($sformatf("sat%0d", i), cap_a[i], t3[i]);

        // Round half-up on the accepted row-0 columns 0, 2, 4.
        doReset();
        applyStimulus(1'b1, 24);
        applyStimulus(1'b1, 1000);
        applyStimulus(1'b1, 23);
        applyStimulus(1'b1, 1000);
        applyStimulus(1'b1, -24);
        repeat (20) applyStimulus(1'b1, 0);
        applyStimulus(1'b0, 0);
        repeat (12) tick();
        checkOutput("round_count", cap_b.size(), 9);
        for (int i = 0; i < 3 && i < cap_b.size(); i++)
            checkRec($sformatf("round%0d", i), cap_b[i], t4[i]);

        // Overflow: depth-4 FIFO with i_ready low takes 6 samples.
        doReset();
        ready = 1'b0;
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 11 + i);
        applyStimulus(1'b0, 0);
        repeat (3) tick();
        checkOutput("ovf_sticky", a_ovf, 1);
        checkOutput("ovf_head_valid", a_valid, 1);
        checkOutput("ovf_head_data", a_data, 11);
        repeat (3) tick();
        checkOutput("ovf_head_stable", a_data, 11);
        checkOutput("ovf_no_pop", cap_a.size(), 0);
        ready = 1'b1;
        repeat (10) tick();
        checkOutput("ovf_drain_count", cap_a.size(), 4);
        for (int i = 0; i < 4 && i < cap_a.size(); i++)
            checkRec($sformatf("drain%0d", i), cap_a[i], t5[i]);
        checkOutput("ovf_still_set", a_ovf, 1);

        // Reset mid-frame after 3 of 4 samples, with entries still queued.
        doReset();
        ready = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1 + i);
        applyStimulus(1'b0, 0);
        checkOutput("pre_reset_valid", a_valid, 1);
        rst = 1'b1;
        #1;
        checkResetOutputs();
        tick();
        rst = 1'b0;
        ready = 1'b1;
        cap_a.delete();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 21 + i);
        applyStimulus(1'b0, 0);
        repeat (8) tick();
        checkOutput("restart_count", cap_a.size(), 4);
        for (int i = 0; i < 4 && i < cap_a.size(); i++)
            checkRec($sformatf("restart%0d", i), cap_a[i], '{0, 21 + i, i / 2, i % 2, (i == 3)});

        // Randomized traffic on both configurations against the queue model.
        doReset();
        for (int n = 0; n < 1500; n++) begin
            bit     e, r;
            longint d;
            logic [63:0] raw;
            compareModel(0);
            compareModel(1);
            e = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) != 0) begin
                d = longint'($urandom_range(0, 80000)) - 40000;
            end else begin
                raw = {$urandom, $urandom};
                d = longint'($signed(raw[47:0]));
            end
            en = e;
            din = d[47:0];
            ready = r;
            modelStep(0, e, d, r);
            modelStep(1, e, d, r);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
